vga_fill_sequencer: RTL
=======================

VGA_FILL_SEQUENCER -- requirements
Module: vga_fill_sequencer

Interface
REQ-001 Clocking SHALL be one clock, with a synchronous, active-high reset.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 addr  in  8  bus address.
REQ-005 data  in  8  bus write data.
REQ-006 BUS_WE  in  1  bus write enable.
REQ-007 px_addr  in  15  single-pixel write address {V[6:0],H[7:0]} from the upstream pixel writer.
REQ-008 px_data  in  1  single-pixel colour.
REQ-009 px_we  in  1  single-pixel write strobe.
REQ-010 fb_addr  out  15  frame-buffer write address {y[6:0],x[7:0]}.
REQ-011 fb_data  out  1  frame-buffer write colour.
REQ-012 fb_we  out  1  frame-buffer write enable.
REQ-013 busy  out  1  high while a fill is in progress (FILL state).
REQ-014 done  out  1  one-cycle pulse on fill completion.

Function
REQ-015 Bus writes (BUS_WE=1) SHALL load these shadow registers: 0xB4 X0, 0xB5 Y0, 0xB6 W, 0xB7 H; all other addresses, except 0xB8 (REQ-016), SHALL be ignored.
REQ-016 A write to 0xB8 SHALL be a command: data[0]=colour, data[1]=start, data[2]=abort.
REQ-017 FSM states SHALL be IDLE, FILL and DONE.
REQ-018 IDLE->FILL: a start command in IDLE with W!=0 and H!=0 SHALL copy the shadow registers into working registers and set x=X0, y=Y0.
REQ-019 IDLE->DONE: a start command with W=0 or H=0 SHALL produce no writes and go straight to DONE.
REQ-020 FILL SHALL emit one pixel per non-stalled cycle in row-major order: x runs X0..X0+W-1, then y increments and x returns to X0.
REQ-021 FILL->DONE SHALL occur after the pixel at (X0+W-1, Y0+H-1) is issued.
REQ-022 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-023 Start commands SHALL be ignored unless the FSM is in IDLE.
REQ-024 Shadow-register writes during FILL SHALL update the shadow registers only and SHALL NOT affect the fill in progress.
REQ-025 An abort command in FILL SHALL return the FSM to IDLE on the next edge, with no done pulse and no further fill writes.
REQ-026 If start and abort are both set in one command, abort SHALL win.
REQ-027 Arbitration: px_we=1 SHALL take priority; in that cycle the fill SHALL stall (counters hold) and the px_* values SHALL be forwarded.
REQ-028 fb_addr, fb_data and fb_we SHALL be registered, with 1-cycle latency from the winning request.
REQ-029 fb_we SHALL be low in any cycle with neither a px_we nor a fill pixel.
REQ-030 Arithmetic: x and y SHALL be 8-bit; X0+W-1 SHALL wrap modulo 256; fb_addr SHALL carry y[6:0] and x[7:0].
REQ-031 Fill duration SHALL be W*H cycles plus one cycle per stall.

Reset
REQ-032 RESET SHALL force: state IDLE; X0, Y0, W, H, colour, x and y = 0; fb_addr=0; fb_data=0; fb_we=0; busy=0; done=0.
REQ-033 RESET during FILL SHALL abandon the fill with no done pulse, and fb_we SHALL be 0 from the next cycle.

Configuration
REQ-034 With FILL_CLIP_EN defined, fill pixels with x>=160 or y>=120 SHALL NOT be written (fb_we=0); each such pixel still consumes a cycle and advances the counters.
REQ-035 Without FILL_CLIP_EN, every fill pixel SHALL be written, with x wrapped mod 256 and y truncated to 7 bits.
REQ-036 FILL_CLIP_EN SHALL NOT affect forwarded px_* writes.

Verification
REQ-037 X0=10, Y0=5, W=3, H=2, then start with colour 1 -> fb_we high 6 cycles; addrs {5,10},{5,11},{5,12},{6,10},{6,11},{6,12}; fb_data=1; one done pulse; busy low afterwards.
REQ-038 W=0, then start -> no fb_we; done pulse exactly 2 cycles after the command edge.
REQ-039 4x1 fill with px_we=1 (px_addr=0x1234) on the 2nd fill cycle -> fb_addr=0x1234 in that slot; fill finishes in 5 cycles; no pixel skipped or repeated.
REQ-040 2x3 fill, abort after 2 pixels -> exactly 2 writes; no done pulse; state IDLE; next start accepted.
REQ-041 FILL_CLIP_EN defined, X0=158, W=4, H=1 -> writes only x=158 and x=159; done after 4 cycles. Without the macro -> 4 writes, x = 158, 159, 160, 161.
REQ-042 RESET mid-fill -> fb_we=0 and busy=0 from the next cycle; rewriting X0 updates the shadow register, and a later start uses the new value.

Source files
------------

// File: rtl/vga_fill_sequencer.sv
// Rectangle fill sequencer arbitrating with a single-pixel writer into a frame buffer.
// Optional FILL_CLIP_EN suppresses fill pixels outside the 160x120 visible area.
module vga_fill_sequencer (
    input  logic        clk,
    input  logic        RESET,
    input  logic [7:0]  addr,
    input  logic [7:0]  data,
    input  logic        BUS_WE,
    input  logic [14:0] px_addr,
    input  logic        px_data,
    input  logic        px_we,
    output logic [14:0] fb_addr,
    output logic        fb_data,
    output logic        fb_we,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t      r_state;
    logic [7:0]  r_x0, r_y0, r_w, r_h;
    logic [7:0]  r_wx0, r_ww, r_wh;
    logic [7:0]  r_col, r_row, r_x, r_y;
    logic        r_colour;
    logic [14:0] r_fb_addr;
    logic        r_fb_data, r_fb_we, r_busy, r_done;

    logic w_cmd, w_start, w_abort, w_vis;
    logic w_last_col, w_last_row, w_unused;

    assign w_cmd      = BUS_WE && (addr == 8'hB8);
    assign w_abort    = w_cmd && data[2];
    assign w_start    = w_cmd && data[1] && !data[2];
    assign w_last_col = (r_col == r_ww - 8'd1);
    assign w_last_row = (r_row == r_wh - 8'd1);
    assign w_unused   = ^{data[7:3], r_y[7]};

`ifdef FILL_CLIP_EN
    assign w_vis = (r_x < 8'd160) && (r_y < 8'd120);
`else
    assign w_vis = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_x0      <= '0;
            r_y0      <= '0;
            r_w       <= '0;
            r_h       <= '0;
            r_wx0     <= '0;
            r_ww      <= '0;
            r_wh      <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_colour  <= 1'b0;
            r_fb_addr <= '0;
            r_fb_data <= 1'b0;
            r_fb_we   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_fb_we <= 1'b0;
            r_done  <= 1'b0;
            if (BUS_WE) begin
                unique case (addr)
                    8'hB4:   r_x0 <= data;
                    8'hB5:   r_y0 <= data;
                    8'hB6:   r_w  <= data;
                    8'hB7:   r_h  <= data;
                    default: ;
                endcase
            end
            // The pixel writer always wins; the fill simply stalls that cycle.
            if (px_we) begin
                r_fb_addr <= px_addr;
                r_fb_data <= px_data;
                r_fb_we   <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_colour <= data[0];
                        if (r_w != 8'd0 && r_h != 8'd0) begin
                            r_wx0   <= r_x0;
                            r_ww    <= r_w;
                            r_wh    <= r_h;
                            r_x     <= r_x0;
                            r_y     <= r_y0;
                            r_col   <= '0;
                            r_row   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_FILL;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_FILL: begin
                    if (w_abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (!px_we) begin
                        r_fb_addr <= {r_y[6:0], r_x};
                        r_fb_data <= r_colour;
                        r_fb_we   <= w_vis;
                        if (w_last_col) begin
                            r_col <= '0;
                            r_x   <= r_wx0;
                            if (w_last_row) begin
                                r_busy  <= 1'b0;
                                r_state <= S_DONE;
                            end else begin
                                r_row <= r_row + 8'd1;
                                r_y   <= r_y + 8'd1;
                            end
                        end else begin
                            r_col <= r_col + 8'd1;
                            r_x   <= r_x + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fb_addr = r_fb_addr;
    assign fb_data = r_fb_data;
    assign fb_we   = r_fb_we;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
